axi_sram_rd_slave: RTL and testbench

- AXI4 read-channel responder (slave) serving instruction/data read requests from the CPU-side bridge; it is the far end of the AR/R channels that the fetch and memory stages consume.
- Accepts one AR transaction at a time, reads a single-port synchronous SRAM word by word and returns R beats carrying the request's ID.
- Honours rready backpressure; supports FIXED, INCR and WRAP bursts.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_sram_rd_slave_if.sv | 31 +++
 rtl/axi_burst_addr_gen.sv | 37 +++
 rtl/axi_sram_rd_slave.sv | 170 +++++++++++++++++
 tb/tb_axi_sram_rd_slave.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-responder FSM state type.
// Imported by the read slave and its burst address generator.
package axi_pkg;

    localparam int ID_W_DEFAULT = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/axi_sram_rd_slave_if.sv
// AXI4 read address (AR) and read data (R) channel bundle.
// The master modport drives requests and rready; the slave modport answers them.
interface axi_sram_rd_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
// WRAP with a beat count other than 2/4/8/16 falls back to INCR.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] bytes_s;
    logic [31:0] incr_s;
    logic [31:0] mask_s;
    logic        wrap_ok_s;

    // Step size, wrap window mask and the selected next address.
    always_comb begin
        bytes_s   = 32'd1 << size;
        incr_s    = addr + bytes_s;
        mask_s    = (({28'd0, len} + 32'd1) << size) - 32'd1;
        wrap_ok_s = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_ok_s) begin
                    next_addr = (addr & ~mask_s) | (incr_s & mask_s);
                end else begin
                    next_addr = incr_s;
                end
            end
            default:     next_addr = incr_s;
        endcase
    end

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read responder over a single-port synchronous SRAM, one beat per 3 cycles.
// Optional macro AXI_RD_RANGE_ERR_EN: out-of-range beats skip the SRAM and return SLVERR.
module axi_sram_rd_slave
    import axi_pkg::*;
#(
    parameter int         ID_W      = ID_W_DEFAULT,
    parameter int         SRAM_AW   = 16,
    parameter logic [1:0] RESP_OKAY = AXI_RESP_OKAY
) (
    input  logic                clk,
    input  logic                resetn,
    axi_sram_rd_slave_if.slave  axi,
    output logic                sram_en,
    output logic [SRAM_AW-1:0]  sram_addr,
    input  logic [31:0]         sram_rdata,
    output logic                busy
);

    state_t              state_r;
    logic [ID_W-1:0]     id_r;
    logic [31:0]         addr_r;
    logic [3:0]          len_r;
    logic [1:0]          size_r;
    logic [1:0]          burst_r;
    logic [3:0]          beat_cnt_r;
    logic                arready_r;
    logic                rvalid_r;
    logic                rlast_r;
    logic [ID_W-1:0]     rid_r;
    logic [31:0]         rdata_r;
    logic [1:0]          rresp_r;
    logic                sram_en_r;
    logic [SRAM_AW-1:0]  sram_addr_r;
    logic                busy_r;

    logic [3:0]          len_in_s;
    logic [1:0]          size_in_s;
    logic [31:0]         next_addr_s;
    logic                ar_err_s;
    logic                nx_err_s;
    logic                cur_err_s;

    // Illegal request lengths and sizes are clamped to the largest legal value.
    always_comb begin
        if (axi.arlen > 8'd15) begin
            len_in_s = 4'd15;
        end else begin
            len_in_s = axi.arlen[3:0];
        end
        if (axi.arsize > 3'd2) begin
            size_in_s = 2'd2;
        end else begin
            size_in_s = axi.arsize[1:0];
        end
    end

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_r),
        .size      (size_r),
        .len       (len_r),
        .burst     (burst_r),
        .next_addr (next_addr_s)
    );

`ifdef AXI_RD_RANGE_ERR_EN
    assign ar_err_s  = (axi.araddr >> (SRAM_AW + 2)) != 32'd0;
    assign nx_err_s  = (next_addr_s >> (SRAM_AW + 2)) != 32'd0;
    assign cur_err_s = (addr_r >> (SRAM_AW + 2)) != 32'd0;
`else
    assign ar_err_s  = 1'b0;
    assign nx_err_s  = 1'b0;
    assign cur_err_s = 1'b0;
`endif

    // Main FSM; sram_en/sram_addr are loaded on entry to ISSUE so they are valid during it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            id_r        <= '0;
            addr_r      <= 32'd0;
            len_r       <= 4'd0;
            size_r      <= 2'd0;
            burst_r     <= 2'd0;
            beat_cnt_r  <= 4'd0;
            arready_r   <= 1'b1;
            rvalid_r    <= 1'b0;
            rlast_r     <= 1'b0;
            rid_r       <= '0;
            rdata_r     <= 32'd0;
            rresp_r     <= 2'b00;
            sram_en_r   <= 1'b0;
            sram_addr_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (axi.arvalid && arready_r) begin
                        id_r        <= axi.arid;
                        addr_r      <= axi.araddr;
                        len_r       <= len_in_s;
                        size_r      <= size_in_s;
                        burst_r     <= axi.arburst;
                        beat_cnt_r  <= 4'd0;
                        arready_r   <= 1'b0;
                        busy_r      <= 1'b1;
                        sram_en_r   <= ~ar_err_s;
                        sram_addr_r <= axi.araddr[SRAM_AW+1:2];
                        state_r     <= ST_ISSUE;
                    end else begin
                        arready_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    sram_en_r <= 1'b0;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    rvalid_r <= 1'b1;
                    rid_r    <= id_r;
                    rlast_r  <= (beat_cnt_r == len_r);
                    if (cur_err_s) begin
                        rdata_r <= 32'h0000_0000;
                        rresp_r <= AXI_RESP_SLVERR;
                    end else begin
                        rdata_r <= sram_rdata;
                        rresp_r <= RESP_OKAY;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (axi.rready) begin
                        rvalid_r <= 1'b0;
                        if (rlast_r) begin
                            arready_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            beat_cnt_r  <= beat_cnt_r + 4'd1;
                            addr_r      <= next_addr_s;
                            sram_en_r   <= ~nx_err_s;
                            sram_addr_r <= next_addr_s[SRAM_AW+1:2];
                            state_r     <= ST_ISSUE;
                        end
                    end else begin
                        rvalid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    sram_en_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign axi.arready = arready_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rlast   = rlast_r;
    assign axi.rid     = rid_r;
    assign axi.rdata   = rdata_r;
    assign axi.rresp   = rresp_r;
    assign sram_en     = sram_en_r;
    assign sram_addr   = sram_addr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Self-checking bench for axi_sram_rd_slave: directed vector table, corner sequences
// and randomized bursts compared against a burst-level reference model.
module tb_axi_sram_rd_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sram_en;
    logic [15:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        busy;

    logic [31:0] mem [0:65535];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_sram_rd_slave_if #(.ID_W(4)) bus ();

    axi_sram_rd_slave #(.ID_W(4), .SRAM_AW(16), .RESP_OKAY(2'b00)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .axi        (bus),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .busy       (busy)
    );

    // Synchronous SRAM: data appears the cycle after a read enable.
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          beats;
        logic [15:0] w [4];
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] got_w [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one burst from posedge+1 with IDLE slave; returns at posedge+1 after the last beat.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                             input int stall_len, input bit rand_stall, input bit hold_ar,
                             input int abort_beat);
        int          n;
        int          sz;
        logic [31:0] bytes;
        logic [31:0] span;
        logic [31:0] a;
        bit          wrap;
        bit          err;
        logic [15:0] e_word [$];
        logic [31:0] e_data [$];
        logic [1:0]  e_resp [$];
        bit          e_err  [$];

        n     = (len > 8'd15) ? 16 : int'(len) + 1;
        sz    = (size > 3'd2) ? 2 : int'(size);
        bytes = 32'd1 << sz;
        span  = 32'(n) * bytes;
        wrap  = (burst == 2'b10) && (n == 2 || n == 4 || n == 8 || n == 16);
        for (int i = 0; i < n; i++) begin
            if (burst == 2'b00) a = addr;
            else if (wrap) a = (addr - (addr % span)) + (((addr % span) + 32'(i) * bytes) % span);
            else a = addr + 32'(i) * bytes;
            err = 1'b0;
`ifdef AXI_RD_RANGE_ERR_EN
            err = (a >= 32'h0004_0000);
`endif
            e_word.push_back(a[17:2]);
            e_err.push_back(err);
            e_data.push_back(err ? 32'h0 : mem[a[17:2]]);
            e_resp.push_back(err ? 2'b10 : 2'b00);
        end

        got_w.delete();
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        chk("arready_idle", 32'(bus.arready), 32'd1);
        @(posedge clk); #1;
        if (hold_ar) begin
            bus.arid   = ~id;
            bus.araddr = 32'h0000_0200;
        end else begin
            bus.arvalid = 1'b0;
        end

        for (int b = 0; b < n; b++) begin
            int          cyc;
            int          en_cnt;
            int          stall;
            logic [31:0] held;
            cyc    = 0;
            en_cnt = 0;
            while (bus.rvalid !== 1'b1 && cyc < 20) begin
                if (sram_en === 1'b1) begin
                    en_cnt++;
                    got_w.push_back(sram_addr);
                    chk("sram_addr", 32'(sram_addr), 32'(e_word[b]));
                end
                chk("arready_busy", 32'(bus.arready), 32'd0);
                chk("busy_high", 32'(busy), 32'd1);
                @(posedge clk); #1;
                cyc++;
            end
            chk("r_latency", 32'(cyc), 32'd2);
            chk("sram_en_pulses", 32'(en_cnt), e_err[b] ? 32'd0 : 32'd1);
            chk("rdata", bus.rdata, e_data[b]);
            chk("rid", 32'(bus.rid), 32'(id));
            chk("rresp", 32'(bus.rresp), 32'(e_resp[b]));
            chk("rlast", 32'(bus.rlast), (b == n - 1) ? 32'd1 : 32'd0);

            if (b == abort_beat) begin
                resetn = 1'b0;
                #1;
                chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
                chk("abort_arready", 32'(bus.arready), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_sram_en", 32'(sram_en), 32'd0);
                bus.arvalid = 1'b0;
                @(posedge clk); #3;
                resetn = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    chk("post_abort_rvalid", 32'(bus.rvalid), 32'd0);
                    chk("post_abort_busy", 32'(busy), 32'd0);
                end
                return;
            end

            held = bus.rdata;
            if (b == stall_beat) stall = stall_len;
            else if (rand_stall) stall = $urandom_range(0, 3);
            else stall = 0;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                chk("bp_rvalid", 32'(bus.rvalid), 32'd1);
                chk("bp_rdata", bus.rdata, held);
                chk("bp_sram_en", 32'(sram_en), 32'd0);
                chk("bp_arready", 32'(bus.arready), 32'd0);
            end
            bus.rready = 1'b1;
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end

        chk("end_rvalid", 32'(bus.rvalid), 32'd0);
        chk("end_arready", 32'(bus.arready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        bus.arvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.arid    = 4'h0;
        bus.araddr  = 32'h0;
        bus.arlen   = 8'd0;
        bus.arsize  = 3'd0;
        bus.arburst = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
        mem[4] = 32'hDEAD_BEEF;

        vecs[0] = '{4'h0, 32'h0000_0010, 8'd0,  3'd2, 2'b01, 1,  '{16'h0004, 16'h0000, 16'h0000, 16'h0000}};
        vecs[1] = '{4'h3, 32'h0000_0100, 8'd3,  3'd2, 2'b01, 4,  '{16'h0040, 16'h0041, 16'h0042, 16'h0043}};
        vecs[2] = '{4'h5, 32'h0000_0108, 8'd3,  3'd2, 2'b10, 4,  '{16'h0042, 16'h0043, 16'h0040, 16'h0041}};
        vecs[3] = '{4'h7, 32'h0000_0020, 8'd2,  3'd2, 2'b00, 3,  '{16'h0008, 16'h0008, 16'h0008, 16'h0000}};
        vecs[4] = '{4'h1, 32'h0000_0101, 8'd3,  3'd0, 2'b01, 4,  '{16'h0040, 16'h0040, 16'h0040, 16'h0041}};
        vecs[5] = '{4'h2, 32'h0000_010C, 8'd2,  3'd2, 2'b10, 3,  '{16'h0043, 16'h0044, 16'h0045, 16'h0000}};
        vecs[6] = '{4'hA, 32'h0000_003C, 8'd20, 3'd3, 2'b10, 16, '{16'h000F, 16'h0000, 16'h0001, 16'h0002}};
        vecs[7] = '{4'hF, 32'h0000_FFFC, 8'd1,  3'd2, 2'b01, 2,  '{16'h3FFF, 16'h4000, 16'h0000, 16'h0000}};

        #12;
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rid", 32'(bus.rid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      -1, 0, 1'b0, 1'b0, -1);
            chk("tbl_beats", 32'(got_w.size()), 32'(vecs[v].beats));
            for (int i = 0; i < 4 && i < vecs[v].beats; i++) begin
                chk("tbl_waddr", 32'(got_w[i]), 32'(vecs[v].w[i]));
            end
        end
        chk("single_read_word", mem[4], 32'hDEAD_BEEF);

        // Backpressure on beat 2 with a competing request held on AR.
        run_burst(4'h3, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 1, 5, 1'b0, 1'b1, -1);
        // Reset during RESP of beat 2, then a fresh request.
        run_burst(4'h4, 32'h0000_0200, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, 1);
        run_burst(4'h6, 32'h0000_0300, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, -1);
        // Upper address bits set: SLVERR when range checking is built in, aliasing otherwise.
        run_burst(4'h9, 32'h0004_0000, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 40; r++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) != 0) ra = ra & 32'h0003_FFFF;
            run_burst(4'($urandom_range(0, 15)), ra, 8'($urandom_range(0, 17)),
                      3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), -1, 0, 1'b1,
                      1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
